// File: rtl/gate_occupancy_ctrl.sv
// Bounded occupancy counter with timed entry/exit gate pulses; strobes that cannot be served pulse reject_o.
// Latency: one cycle from strobe to count/flags/gate/reject update; gate held for GATE_CYCLES cycles.
// Backpressure: none; strobes arriving while a gate is open are refused, never queued.
module gate_occupancy_ctrl #(
    parameter int CAPACITY    = 9,
    parameter int CNT_W       = 4,
    parameter int GATE_CYCLES = 100,
    parameter int TMR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_i,
    input  logic             exit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             gate_in_o,
    output logic             gate_out_o,
    output logic             busy_o,
    output logic             reject_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_OPEN  = 2'd1,
        OUT_OPEN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               gate_in_q, gate_in_d;
    logic               gate_out_q, gate_out_d;
    logic               reject_q, reject_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        gate_in_d  = gate_in_q;
        gate_out_d = gate_out_q;
        reject_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Simultaneous entry and exit cancel out: no branch taken.
                if (entry_i && !exit_i) begin
                    if (cnt_q < CAP) begin
                        cnt_d     = cnt_q + 1'b1;
                        tmr_d     = TMR_LOAD;
                        state_d   = IN_OPEN;
                        gate_in_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (exit_i && !entry_i) begin
                    if (cnt_q != '0) begin
                        cnt_d      = cnt_q - 1'b1;
                        tmr_d      = TMR_LOAD;
                        state_d    = OUT_OPEN;
                        gate_out_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            IN_OPEN, OUT_OPEN: begin
                reject_d = entry_i | exit_i;
                if (tmr_q == '0) begin
                    state_d    = IDLE;
                    gate_in_d  = 1'b0;
                    gate_out_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                gate_in_d  = 1'b0;
                gate_out_d = 1'b0;
            end
        endcase

        // Flags follow the next-state count so they line up with count_o.
        full_d  = (cnt_d == CAP);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            gate_in_q  <= 1'b0;
            gate_out_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            gate_in_q  <= gate_in_d;
            gate_out_q <= gate_out_d;
            reject_q   <= reject_d;
        end
    end

    assign count_o    = cnt_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign gate_in_o  = gate_in_q;
    assign gate_out_o = gate_out_q;
    assign busy_o     = (state_q != IDLE);
    assign reject_o   = reject_q;

endmodule

// File: tb/tb_gate_occupancy_ctrl.sv
// Scoreboard bench for gate_occupancy_ctrl with CAPACITY=3, GATE_CYCLES=4.
module tb_gate_occupancy_ctrl;

    localparam int CAP = 3;
    localparam int G   = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_s = 1'b0;
    logic       exit_s  = 1'b0;
    logic [3:0] count_o;
    logic       full_o, empty_o, gate_in_o, gate_out_o, busy_o, reject_o;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    string      lbl_q[$];

    gate_occupancy_ctrl #(
        .CAPACITY   (CAP),
        .CNT_W      (4),
        .GATE_CYCLES(G),
        .TMR_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entry_i   (entry_s),
        .exit_i    (exit_s),
        .count_o   (count_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .gate_in_o (gate_in_o),
        .gate_out_o(gate_out_o),
        .busy_o    (busy_o),
        .reject_o  (reject_o)
    );

    always #5 clk = ~clk;

    // Expected vector: {count, full, empty, gate_in, gate_out, busy, reject}
    function automatic logic [9:0] mk(input int cnt, input bit gin, input bit gout, input bit rej);
        logic [3:0] c;
        c = 4'(cnt);
        return {c, (cnt == CAP), (cnt == 0), gin, gout, (gin | gout), rej};
    endfunction

    task automatic step(input bit en, input bit ex, input int cnt, input bit gin,
                        input bit gout, input bit rej, input string l);
        @(negedge clk);
        entry_s = en;
        exit_s  = ex;
        exp_q.push_back(mk(cnt, gin, gout, rej));
        lbl_q.push_back(l);
    endtask

    // Accepted event followed by the full open window and the closing cycle.
    task automatic gate_evt(input bit is_in, input int cnt, input string l);
        step(is_in, !is_in, cnt, is_in, !is_in, 1'b0, l);
        for (int i = 0; i < G - 1; i++)
            step(1'b0, 1'b0, cnt, is_in, !is_in, 1'b0, {l, "_open"});
        step(1'b0, 1'b0, cnt, 1'b0, 1'b0, 1'b0, {l, "_closed"});
    endtask

    // Monitor: compares on every clock edge and on asynchronous reset assertion.
    initial begin
        logic [9:0] act, e;
        string      l;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                l   = lbl_q.pop_front();
                act = {count_o, full_o, empty_o, gate_in_o, gate_out_o, busy_o, reject_o};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got cnt=%0d full=%b empty=%b gin=%b gout=%b busy=%b rej=%b, want cnt=%0d full=%b empty=%b gin=%b gout=%b busy=%b rej=%b",
                             l, act[9:6], act[5], act[4], act[3], act[2], act[1], act[0],
                             e[9:6], e[5], e[4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, "reset_a");
        step(0, 0, 0, 0, 0, 0, "reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, "idle_after_reset");

        gate_evt(1'b1, 1, "entry1");
        gate_evt(1'b1, 2, "entry2");
        gate_evt(1'b1, 3, "entry3_full");
        step(1, 0, 3, 0, 0, 1, "entry_when_full");
        step(0, 0, 3, 0, 0, 0, "full_reject_clear");

        gate_evt(1'b0, 2, "exit_to2");
        step(1, 1, 2, 0, 0, 0, "simultaneous");
        step(0, 0, 2, 0, 0, 0, "simultaneous_after");

        gate_evt(1'b0, 1, "exit_to1");
        gate_evt(1'b0, 0, "exit_to_empty");
        step(0, 1, 0, 0, 0, 1, "exit_when_empty");
        step(0, 1, 0, 0, 0, 1, "exit_when_empty_again");
        step(0, 0, 0, 0, 0, 0, "empty_reject_clear");

        step(1, 0, 1, 1, 0, 0, "entry_open");
        step(0, 0, 1, 1, 0, 0, "open_c1");
        step(0, 1, 1, 1, 0, 1, "exit_in_open_c2");
        step(0, 0, 1, 1, 0, 0, "open_c3");
        step(1, 0, 1, 0, 0, 1, "entry_in_last_open");
        gate_evt(1'b1, 2, "entry_after_close");

        step(0, 1, 1, 0, 1, 0, "exit_before_reset");
        step(0, 0, 1, 0, 1, 0, "gout_c2");
        step(0, 0, 1, 0, 1, 0, "gout_c3");
        @(posedge clk);
        #3;
        exp_q.push_back(mk(0, 0, 0, 0));
        lbl_q.push_back("async_reset");
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, "held_reset_a");
        step(0, 0, 0, 0, 0, 0, "held_reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 0, 1, "exit_after_reset");
        step(0, 0, 0, 0, 0, 0, "final_idle");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_occupancy_ctrl.md
# gate_occupancy_ctrl

Consumes the one-cycle `entry` and `exit` strobes produced by the push-button debounce/one-pulse front end. It maintains a bounded occupancy count and drives an entry or exit gate-open output for a fixed number of cycles per accepted event. Strobes that cannot be honoured are flagged on `reject`. The block sits between the button front end and the display/actuator logic.

## Interface
- `CAPACITY`, default 9: maximum occupancy; valid range 1..2^CNT_W-1.
- `CNT_W`, default 4: width of the occupancy count.
- `GATE_CYCLES`, default 100: number of cycles a gate output stays high; must be ≥1.
- `TMR_W`, default 16: width of the gate timer; must satisfy GATE_CYCLES ≤ 2^TMR_W.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `entry`, input, 1: one-cycle strobe requesting admission.
- `exit`, input, 1: one-cycle strobe requesting departure.
- `count`, output, CNT_W: current occupancy, registered.
- `full`, output, 1: high when count == CAPACITY, registered.
- `empty`, output, 1: high when count == 0, registered.
- `gate_in`, output, 1: entry gate open, registered.
- `gate_out`, output, 1: exit gate open, registered.
- `busy`, output, 1: high when the FSM is not in IDLE.
- `reject`, output, 1: one-cycle pulse when a strobe is refused.

## Operation
- **States:** IDLE, IN_OPEN, OUT_OPEN. The timer `tmr` is TMR_W bits wide.
- **Reset:** state = IDLE, count = 0, tmr = 0, empty = 1, full = 0, gate_in = 0, gate_out = 0, busy = 0, reject = 0. Assertion at any time aborts an open gate immediately.

**IDLE, on each edge:**
- `entry` && !`exit` && count < CAPACITY:
  - count ← count + 1.
  - tmr ← GATE_CYCLES − 1.
  - Go to IN_OPEN; gate_in ← 1.
- `entry` && !`exit` && count == CAPACITY: reject ← 1 for one cycle; nothing else changes.
- `exit` && !`entry` && count > 0:
  - count ← count − 1.
  - tmr ← GATE_CYCLES − 1.
  - Go to OUT_OPEN; gate_out ← 1.
- `exit` && !`entry` && count == 0: reject ← 1 for one cycle; nothing else changes.
- `entry` && `exit` together: the requests cancel. Count is unchanged, no gate opens, and no reject is issued.

**IN_OPEN / OUT_OPEN, on each edge:**
- If tmr == 0: go to IDLE; the gate output ← 0.
- Otherwise: tmr ← tmr − 1.
- Any `entry` or `exit` strobe in these states is refused: reject ← 1 for one cycle, and count and timer are unaffected. Strobes are not queued.

**Other rules:**
- `full` and `empty` are registered from the next-state count, so they always match `count` on the same cycle.
- Count arithmetic never wraps: the CAPACITY and 0 bounds are checked before any update.
- gate_in and gate_out are never high at the same time.
- busy == gate_in | gate_out.

## Timing
- **Latency:** a strobe high in cycle t is sampled at the edge ending cycle t. count, flags, gate and reject reflect it from cycle t+1.
- **Gate duration:** a gate output is high for exactly GATE_CYCLES cycles, t+1 .. t+GATE_CYCLES. The FSM is back in IDLE at t+GATE_CYCLES+1.
- **Earliest next event:** a strobe in cycle t+GATE_CYCLES+1 is accepted. A strobe in cycle t+GATE_CYCLES (last open cycle) is rejected.
- **GATE_CYCLES = 1:** the gate is high for one cycle, and back-to-back accepted events are spaced two cycles apart.
- **reject width:** always exactly one cycle per refused strobe, including refusals on consecutive cycles.
- **Reset timing:** asynchronous assertion drives all outputs to their reset values without waiting for a clock edge. Deassertion is assumed synchronous to `clk` upstream.

## Test plan
- **Reset and first entry** (CAPACITY=3, GATE_CYCLES=4): reset, then `entry` pulse → count 0→1 next cycle; empty 1→0; gate_in high exactly 4 cycles; busy matches gate_in; reject stays 0.
- **Fill to capacity:** 3 spaced `entry` pulses → count=3, full=1. A 4th `entry` → reject pulses 1 cycle; count stays 3; gate_in stays 0.
- **Empty boundary:** from count=1, `exit` → count=0, empty=1, gate_out high 4 cycles. Another `exit` → reject 1 cycle; count stays 0.
- **Strobes while open:** `entry` accepted; `exit` in the 2nd open cycle and `entry` in the 4th (last) open cycle → two reject pulses. Count changes only by the first entry. The gate closes on schedule, and an `entry` one cycle later is accepted.
- **Simultaneous strobes:** `entry` and `exit` in the same IDLE cycle at count=2 → count stays 2; no gate; no reject; busy stays 0.
- **Reset mid-operation:** assert `rst_n`=0 during the 3rd cycle of gate_out → gate_out, busy and count go to 0 and empty to 1 immediately (asynchronously). After release, an `exit` is rejected.
